// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - RV32I funct3 width codes for loads and stores
//   - FSM state encoding
//   - is_fault(): legality check applied to a request at accept time
// -----------------------------------------------------------------------------
package lsu_pkg;

  // Load width codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store width codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    FAULT = 3'd4
  } lsu_state_t;

  // Misaligned halfword/word accesses and unused funct3 codes are faults.
  function automatic logic is_fault(input logic       we,
                                    input logic [2:0] funct3,
                                    input logic [1:0] addr_lo);
    logic f;
    f = 1'b0;
    if (we) begin
      case (funct3)
        F3_SB:   f = 1'b0;
        F3_SH:   f = addr_lo[0];
        F3_SW:   f = |addr_lo;
        default: f = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: f = 1'b0;
        F3_LH, F3_LHU: f = addr_lo[0];
        F3_LW:         f = |addr_lo;
        default:       f = 1'b1;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// -----------------------------------------------------------------------------
// lsu_lane
// Purely combinational byte-lane logic for the load/store unit.
//   i_funct3     : width code of the access in flight
//   i_addr_lo    : byte offset within the word
//   i_rdata      : word read from memory
//   i_wdata      : store data (LSBs used for SB/SH)
//   o_load_data  : addressed lane, sign/zero extended per funct3
//   o_merge_data : i_rdata with the store lane(s) replaced by store data
// -----------------------------------------------------------------------------
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_load_data = i_rdata;
    case (i_funct3)
      F3_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_load_data = {24'd0, w_byte};
      F3_LH:   o_load_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_load_data = {16'd0, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

  // Each byte lane independently chooses memory data or store data.
  // SH feeds wdata[7:0] to the even lane and wdata[15:8] to the odd lane.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       w_sel;
      logic [7:0] w_src;

      assign w_sel = (i_funct3 == F3_SW) ||
                     ((i_funct3 == F3_SB) && (i_addr_lo == LANE)) ||
                     ((i_funct3 == F3_SH) && (i_addr_lo[1] == LANE[1]));

      assign w_src = (i_funct3 == F3_SB) ? i_wdata[7:0] :
                     (i_funct3 == F3_SH) ? i_wdata[8*(gi%2) +: 8] :
                                           i_wdata[8*gi +: 8];

      assign o_merge_data[8*gi +: 8] = w_sel ? w_src : i_rdata[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// RV32I load/store unit in front of a unified word-wide memory with a
// registered read port. One access in flight at a time.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready        : request handshake (ready only when idle)
//   req_we, req_funct3         : store flag and RV32I width code
//   req_addr, req_wdata        : byte address and store data
//   rsp_valid/rsp_rdata/rsp_fault : one-cycle completion pulse with result
//   mem_addr, mem_write_en, mem_write_data, mem_read_data : memory port
// Latencies from the accept edge: SW/fault 1, loads 2, SB/SH 3
// (read-modify-write).
// -----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_write_en,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  lsu_state_t  r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_wdata;
  logic [31:0] r_mem_addr;
  logic        r_mem_we;
  logic [31:0] r_mem_wdata;
  logic        r_rsp_valid;
  logic        r_rsp_fault;

  logic [31:0] w_load_data;
  logic [31:0] w_merge_data;

  lsu_lane u_lane (
    .i_funct3     (r_funct3),
    .i_addr_lo    (r_addr_lo),
    .i_rdata      (mem_read_data),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr_lo   <= 2'd0;
      r_wdata     <= 32'd0;
      r_mem_addr  <= 32'd0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= 1'b0;
    end else begin
      // Pulse outputs default low; each state sets them for the next cycle.
      r_mem_we    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_funct3   <= req_funct3;
            r_addr_lo  <= req_addr[1:0];
            r_wdata    <= req_wdata;
            r_mem_addr <= {req_addr[31:2], 2'b00};
            if (is_fault(req_we, req_funct3, req_addr[1:0])) begin
              r_state     <= FAULT;
              r_rsp_valid <= 1'b1;
              r_rsp_fault <= 1'b1;
            end else if (req_we && (req_funct3 == F3_SW)) begin
              // Full-word store needs no read: write straight away.
              r_state     <= WRITE;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= req_wdata;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= READ;
            end
          end
        end
        READ: begin
          // Memory samples mem_addr on this edge; data is valid in DATA.
          r_state     <= DATA;
          r_rsp_valid <= !r_we;
        end
        DATA: begin
          if (r_we) begin
            r_state     <= WRITE;
            r_mem_we    <= 1'b1;
            r_mem_wdata <= w_merge_data;
            r_rsp_valid <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        WRITE:   r_state <= IDLE;
        FAULT:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready      = (r_state == IDLE);
  assign rsp_valid      = r_rsp_valid;
  assign rsp_fault      = r_rsp_fault;
  assign mem_addr       = r_mem_addr;
  assign mem_write_en   = r_mem_we;
  assign mem_write_data = r_mem_wdata;
  // Load data comes straight from the registered memory output in DATA.
  assign rsp_rdata      = ((r_state == DATA) && !r_we) ? w_load_data : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_addr;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_fault      (rsp_fault),
    .mem_addr       (mem_addr),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // Unified memory with registered read.
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr[11:2]] <= mem_write_data;
    mem_read_data <= mem[mem_addr[11:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge; returns at the negedge one cycle after accept.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    check("ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    $display("REQ we=%0d f3=%0d addr=%h wdata=%h", we, f3, addr, wd);
  endtask

  task automatic load_check(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] exp);
    issue(1'b0, f3, addr, 32'd0);
    check({tag, "_c1_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_c1_addr"}, mem_addr, {addr[31:2], 2'b00});
    @(negedge clk);
    check({tag, "_c2_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_c2_rdata"}, rsp_rdata, exp);
    check({tag, "_c2_fault"}, 32'(rsp_fault), 32'd0);
    @(negedge clk);
    check({tag, "_c3_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_c3_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic sw_check(input string tag, input logic [31:0] addr, input logic [31:0] wd);
    issue(1'b1, F3_SW, addr, wd);
    check({tag, "_we"}, 32'(mem_write_en), 32'd1);
    check({tag, "_addr"}, mem_addr, addr);
    check({tag, "_wdata"}, mem_write_data, wd);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_fault"}, 32'(rsp_fault), 32'd0);
    check({tag, "_rdata"}, rsp_rdata, 32'd0);
    @(negedge clk);
    check({tag, "_we_drop"}, 32'(mem_write_en), 32'd0);
    check({tag, "_mem"}, mem[addr[11:2]], wd);
  endtask

  task automatic fault_check(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr);
    issue(we, f3, addr, 32'hFFFF_FFFF);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_fault"}, 32'(rsp_fault), 32'd1);
    check({tag, "_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_we"}, 32'(mem_write_en), 32'd0);
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, "_fault_drop"}, 32'(rsp_fault), 32'd0);
    check({tag, "_we_after"}, 32'(mem_write_en), 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_fault", 32'(rsp_fault), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_mwe", 32'(mem_write_en), 32'd0);
    check("rst_mwdata", mem_write_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload memory through full-word stores
    sw_check("sw_init0", 32'h100, 32'h8899AABB);
    sw_check("sw_init1", 32'h104, 32'h11223344);

    // Loads from 0x100 = 0x8899AABB
    load_check("lb_101",  F3_LB,  32'h101, 32'hFFFFFFAA);
    load_check("lbu_103", F3_LBU, 32'h103, 32'h00000088);
    load_check("lh_102",  F3_LH,  32'h102, 32'hFFFF8899);
    load_check("lhu_100", F3_LHU, 32'h100, 32'h0000AABB);
    load_check("lw_100",  F3_LW,  32'h100, 32'h8899AABB);
    load_check("lb_100",  F3_LB,  32'h100, 32'hFFFFFFBB);

    // SB 0x102: read-modify-write, write on cycle 3
    issue(1'b1, F3_SB, 32'h102, 32'h12345678);
    check("sb_c1_we", 32'(mem_write_en), 32'd0);
    check("sb_c1_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("sb_c2_we", 32'(mem_write_en), 32'd0);
    check("sb_c2_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("sb_c3_we", 32'(mem_write_en), 32'd1);
    check("sb_c3_addr", mem_addr, 32'h100);
    check("sb_c3_wdata", mem_write_data, 32'h8878AABB);
    check("sb_c3_valid", 32'(rsp_valid), 32'd1);
    check("sb_c3_rdata", rsp_rdata, 32'd0);
    check("sb_c3_fault", 32'(rsp_fault), 32'd0);
    @(negedge clk);
    check("sb_c4_we", 32'(mem_write_en), 32'd0);
    check("sb_c4_ready", 32'(req_ready), 32'd1);
    check("sb_mem", mem[32'h100 >> 2], 32'h8878AABB);
    load_check("lw_after_sb", F3_LW, 32'h100, 32'h8878AABB);

    // SH upper half of 0x104 = 0x11223344
    issue(1'b1, F3_SH, 32'h106, 32'h0000BEEF);
    @(negedge clk);
    @(negedge clk);
    check("sh_hi_wdata", mem_write_data, 32'hBEEF3344);
    @(negedge clk);
    check("sh_hi_mem", mem[32'h104 >> 2], 32'hBEEF3344);

    // SW to 0x200
    sw_check("sw_200", 32'h200, 32'hDEADBEEF);

    // Faults
    fault_check("flt_lh_101", 1'b0, F3_LH, 32'h101);
    fault_check("flt_sw_202", 1'b1, F3_SW, 32'h202);
    fault_check("flt_lw_102", 1'b0, F3_LW, 32'h102);
    fault_check("flt_ld_011", 1'b0, 3'b011, 32'h100);
    fault_check("flt_st_100", 1'b1, 3'b100, 32'h100);
    check("flt_sw_mem", mem[32'h200 >> 2], 32'hDEADBEEF);

    // Reset asserted during WRITE of SH 0x104
    issue(1'b1, F3_SH, 32'h104, 32'h0000CAFE);
    @(negedge clk);
    @(negedge clk);
    check("rstw_we_before", 32'(mem_write_en), 32'd1);
    check("rstw_wdata", mem_write_data, 32'hBEEFCAFE);
    rst_n = 1'b0;
    #1;
    check("rstw_we_drop", 32'(mem_write_en), 32'd0);
    check("rstw_valid", 32'(rsp_valid), 32'd0);
    check("rstw_ready", 32'(req_ready), 32'd1);
    check("rstw_maddr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rstw_mem", mem[32'h104 >> 2], 32'hBEEF3344);
    @(negedge clk);
    check("rstw_ready_after", 32'(req_ready), 32'd1);
    check("rstw_no_rsp", 32'(rsp_valid), 32'd0);

    // Two back-to-back LWs with req_valid held high
    @(negedge clk);
    req_we = 1'b0; req_funct3 = F3_LW; req_addr = 32'h100; req_valid = 1'b1;
    check("b2b_ready0", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h200;
    check("b2b_c1_ready", 32'(req_ready), 32'd0);
    check("b2b_c1_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("b2b_c2_valid", 32'(rsp_valid), 32'd1);
    check("b2b_c2_rdata", rsp_rdata, 32'h8878AABB);
    check("b2b_c2_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("b2b_c3_ready", 32'(req_ready), 32'd1);
    check("b2b_c3_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_c4_ready", 32'(req_ready), 32'd0);
    check("b2b_c4_addr", mem_addr, 32'h200);
    check("b2b_c4_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("b2b_c5_valid", 32'(rsp_valid), 32'd1);
    check("b2b_c5_rdata", rsp_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_no_dup", 32'(rsp_valid), 32'd0);
    end
    check("b2b_idle_ready", 32'(req_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1 (all state on rising edge); rst_n in 1 (asynchronous, active-low reset).
REQ-002 SHALL have: req_valid in 1 (pipeline access request); req_ready out 1 (request accepted when valid&&ready); req_we in 1 (1=store, 0=load); req_funct3 in 3 (RV32I width code); req_addr in 32 (byte address); req_wdata in 32 (store data, LSBs used for SB/SH).
REQ-003 SHALL have: rsp_valid out 1 (one-cycle completion pulse); rsp_rdata out 32 (load result); rsp_fault out 1 (misaligned or illegal funct3).
REQ-004 SHALL have: mem_addr out 32 (word-aligned address to unified memory); mem_write_en out 1; mem_write_data out 32; mem_read_data in 32 (memory registered read, valid the cycle after mem_addr is sampled).

Function
REQ-005 SHALL implement FSM states IDLE, READ, DATA, WRITE, FAULT; req_ready=1 only in IDLE.
REQ-006 On accept, SHALL register req_we, req_funct3, req_addr[1:0], req_wdata, and mem_addr={req_addr[31:2],2'b00}.
REQ-007 Transition from IDLE on accept: fault -> FAULT; SW -> WRITE; loads and SB/SH -> READ.
REQ-008 Fault: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3 >= 011.
REQ-009 READ SHALL hold mem_addr, mem_write_en=0, and go unconditionally to DATA.
REQ-010 DATA, load: rsp_valid=1, rsp_rdata=extracted lane, then IDLE; latency 2 cycles after accept edge.
REQ-011 Lane extract: LB/LBU byte at addr[1:0], LH/LHU halfword at addr[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW full word.
REQ-012 DATA, SB/SH: register merged word = mem_read_data with the addressed byte/halfword replaced by req_wdata[7:0]/[15:0], then go to WRITE.
REQ-013 WRITE SHALL assert mem_write_en=1 for exactly one cycle with mem_write_data=merged word (or req_wdata for SW), assert rsp_valid=1 with rsp_rdata=0 in the same cycle, then go to IDLE; SW latency 1, SB/SH latency 3.
REQ-014 FAULT SHALL assert rsp_valid=1, rsp_fault=1, rsp_rdata=0 for one cycle with no memory write, then go to IDLE.
REQ-015 rsp_fault SHALL be 0 whenever rsp_valid is 0 or the access is legal; rsp_rdata SHALL be 0 outside load responses.
REQ-016 mem_write_en SHALL never be asserted outside WRITE; mem_addr SHALL hold its last value in IDLE.
REQ-017 req_valid high while busy SHALL be ignored; the next request SHALL be accepted no earlier than the cycle after rsp_valid.
REQ-018 Address arithmetic SHALL be 32-bit unsigned; no address wrap handling beyond truncation.

Reset
REQ-019 rst_n low SHALL immediately force state IDLE, registered fields 0, and req_ready=1, with rsp_valid, rsp_fault, rsp_rdata, mem_addr, mem_write_en, and mem_write_data all 0.
REQ-020 Reset asserted mid-access (including WRITE) SHALL abort it with no write committed after assertion and no response issued.

Structure
REQ-021 The shared package lsu_pkg SHALL hold the funct3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW) and the FSM state encoding.
REQ-022 Combinational lane extract/merge SHALL live in sub-module lsu_lane; the FSM and registers stay in load_store_unit.

Verification
REQ-023 Word 0x100=0x8899AABB: LB 0x101 -> rsp_valid at cycle 2, rsp_rdata=0xFFFFFFAA; LBU 0x103 -> 0x00000088; LH 0x102 -> 0xFFFF8899.
REQ-024 Same word, SB 0x102 wdata 0x12345678 -> cycle 3 mem_write_en=1, mem_addr=0x100, mem_write_data=0x8878AABB, rsp_valid=1.
REQ-025 SW 0x200 wdata 0xDEADBEEF -> cycle 1 mem_write_en=1, mem_addr=0x200, mem_write_data=0xDEADBEEF, rsp_valid=1, rsp_fault=0.
REQ-026 LH 0x101 and SW 0x202 -> cycle 1 rsp_valid=1, rsp_fault=1, rsp_rdata=0, mem_write_en never asserted.
REQ-027 SH 0x104 with rst_n pulled low in WRITE -> mem_write_en drops to 0 immediately; after release, req_ready=1 and the word is unchanged.
REQ-028 req_valid held high for two LWs -> second accepted the cycle after the first rsp_valid, with no request lost or duplicated.
